// File: rtl/ising_pkg.sv
// Shared definitions for the oscillator-array readout: FSM encodings, default
// window lengths and spin polarity.
package ising_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int   DEF_SETTLE_CYCLES = 16;
    localparam int   DEF_SAMPLE_CYCLES = 64;
    localparam logic SPIN_ANTI         = 1'b1;

    // Phase counter width: large enough for the longer of the two windows.
    function automatic int ph_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) m = 2;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spin_readout_sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser, asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/spin_readout.sv
// spin_readout: counts per-oscillator phase mismatches against a reference over
// a fixed window and resolves each to a spin. SPIN_READOUT_COUNTS_EN exposes the raw counts.
module spin_readout
    import ising_pkg::*;
#(
    parameter int N             = 8,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int CNT_W         = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N-1:0]         osc_in,
    input  logic                 ref_in,
    output logic                 busy,
    output logic                 valid,
`ifdef SPIN_READOUT_COUNTS_EN
    output logic [N-1:0]         spins,
    output logic [N*CNT_W-1:0]   counts
`else
    output logic [N-1:0]         spins
`endif
);

    localparam int              PH_W      = ph_width(SETTLE_CYCLES, SAMPLE_CYCLES);
    localparam logic [PH_W-1:0] SETTLE_LD = PH_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [PH_W-1:0] MEAS_LD   = PH_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(SAMPLE_CYCLES / 2);

    logic [N-1:0]            w_osc;
    logic                    w_ref;
    state_t                  r_state, w_next;
    logic [PH_W-1:0]         r_phase, w_ph_val;
    logic                    w_ph_load;
    logic [N-1:0][CNT_W-1:0] r_cnt;
    logic [N-1:0]            w_spins;
    logic [N-1:0]            r_spins;
    logic                    r_valid;

    for (genvar g = 0; g < N; g++) begin : g_osc_sync
        sync_2ff u_sync (.clk(clk), .rst(rst), .d(osc_in[g]), .q(w_osc[g]));
    end
    sync_2ff u_ref_sync (.clk(clk), .rst(rst), .d(ref_in), .q(w_ref));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Phase counter is loaded with (window-1) and expires when it reaches 0.
    always_comb begin
        w_next    = r_state;
        w_ph_load = 1'b0;
        w_ph_val  = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_ph_load = 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        w_next   = MEASURE;
                        w_ph_val = MEAS_LD;
                    end else begin
                        w_next   = SETTLE;
                        w_ph_val = SETTLE_LD;
                    end
                end
            end
            SETTLE: begin
                if (r_phase == '0) begin
                    w_next    = MEASURE;
                    w_ph_load = 1'b1;
                    w_ph_val  = MEAS_LD;
                end
            end
            MEASURE: begin
                if (r_phase == '0) w_next = DONE;
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_phase <= '0;
        else if (w_ph_load)       r_phase <= w_ph_val;
        else if (r_phase != '0)   r_phase <= r_phase - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && start) begin
            r_cnt <= '0;
        end else if (r_state == MEASURE) begin
            for (int i = 0; i < N; i++)
                r_cnt[i] <= r_cnt[i] + CNT_W'(w_osc[i] ^ w_ref);
        end
    end

    // Exact half of the window resolves to in-phase.
    always_comb begin
        w_spins = '0;
        for (int i = 0; i < N; i++)
            w_spins[i] = (r_cnt[i] > HALF) ? SPIN_ANTI : ~SPIN_ANTI;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_spins <= '0;
        end else begin
            r_valid <= (r_state == DONE);
            if (r_state == DONE) r_spins <= w_spins;
        end
    end

`ifdef SPIN_READOUT_COUNTS_EN
    logic [N*CNT_W-1:0] r_counts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_counts <= '0;
        end else if (r_state == DONE) begin
            for (int i = 0; i < N; i++)
                r_counts[i*CNT_W +: CNT_W] <= r_cnt[i];
        end
    end

    assign counts = r_counts;
`endif

    assign busy  = (r_state == SETTLE) || (r_state == MEASURE);
    assign valid = r_valid;
    assign spins = r_spins;

endmodule
